addsub_pipe: RTL and testbench

ADDSUB_PIPE -- requirements
Module: addsub_pipe

---
 rtl/addsub_pkg.sv | 15 +
 rtl/addsub_lane.sv | 92 +++++++++
 rtl/addsub_pipe.sv | 84 ++++++++
 tb/tb_addsub_pipe.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared constants and types for the addsub_pipe multi-lane adder/subtractor.
// Lane results are carried in a fixed-width struct; lanes use the low DATA_SIZE bits.
package addsub_pkg;

  localparam logic OP_ADD     = 1'b1;
  localparam logic OP_SUB     = 1'b0;
  localparam int   OVF_CNT_W  = 16;
  localparam int   LANE_W_MAX = 64;

  typedef struct packed {
    logic [LANE_W_MAX-1:0] value;
    logic                  ovf;
  } lane_res_t;

endpackage

// File: rtl/addsub_lane.sv
// One add/sub lane: stage 1 forms the one-bit-extended result, stage 2 detects overflow
// and wraps, or clamps when ADDSUB_SAT_EN is defined.
module addsub_lane
  import addsub_pkg::*;
#(
  parameter int DATA_SIZE = 15,
  parameter int SIGNED    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s1_load_i,
  input  logic                 s2_load_i,
  input  logic                 op_i,
  input  logic [DATA_SIZE-1:0] a_i,
  input  logic [DATA_SIZE-1:0] b_i,
  output logic [DATA_SIZE-1:0] result_o,
  output logic                 ovf_o
);

  logic [DATA_SIZE:0]   a_ext, b_ext, sum_d, sum_q;
  logic                 ovf_d;
  logic [DATA_SIZE-1:0] val_d;
  lane_res_t            res_d, res_q;
  logic                 unused_value;

  // The extra bit holds the true sign (signed) or carry/borrow (unsigned) of the result.
  always_comb begin
    a_ext = (SIGNED != 0) ? {a_i[DATA_SIZE-1], a_i} : {1'b0, a_i};
    b_ext = (SIGNED != 0) ? {b_i[DATA_SIZE-1], b_i} : {1'b0, b_i};
    sum_d = a_ext - b_ext;
    case (op_i)
      OP_ADD:  sum_d = a_ext + b_ext;
      OP_SUB:  sum_d = a_ext - b_ext;
      default: ;
    endcase
  end

`ifdef ADDSUB_SAT_EN
  logic op_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
      op_q  <= OP_SUB;
    end else if (s1_load_i) begin
      sum_q <= sum_d;
      op_q  <= op_i;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else if (s1_load_i) begin
      sum_q <= sum_d;
    end
  end
`endif

  always_comb begin
    ovf_d = (SIGNED != 0) ? (sum_q[DATA_SIZE] ^ sum_q[DATA_SIZE-1]) : sum_q[DATA_SIZE];
    val_d = sum_q[DATA_SIZE-1:0];
`ifdef ADDSUB_SAT_EN
    if (ovf_d) begin
      if (SIGNED != 0) begin
        // Negative true sign clamps to the minimum, positive to the maximum.
        val_d              = '0;
        val_d[DATA_SIZE-1] = 1'b1;
        if (!sum_q[DATA_SIZE]) val_d = ~val_d;
      end else begin
        val_d = (op_q == OP_ADD) ? '1 : '0;
      end
    end
`endif
    res_d                        = '0;
    res_d.value[DATA_SIZE-1:0]   = val_d;
    res_d.ovf                    = ovf_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
    end else if (s2_load_i) begin
      res_q <= res_d;
    end
  end

  assign result_o     = res_q.value[DATA_SIZE-1:0];
  assign ovf_o        = res_q.ovf;
  assign unused_value = ^res_q.value;

endmodule

// File: rtl/addsub_pipe.sv
// Two-stage, LANES-wide add/sub pipeline with valid/ready handshakes and an overflow counter.
// Define ADDSUB_SAT_EN to clamp overflowing lanes instead of wrapping.
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int DATA_SIZE = 15,
  parameter int LANES     = 4,
  parameter int SIGNED    = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES-1:0]           in_op,
  input  logic [LANES*DATA_SIZE-1:0] in_a,
  input  logic [LANES*DATA_SIZE-1:0] in_b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*DATA_SIZE-1:0] out_result,
  output logic [LANES-1:0]           out_ovf,
  input  logic                       ovf_clr,
  output logic [OVF_CNT_W-1:0]       ovf_count
);

  logic                 s1_valid_q, s1_valid_d;
  logic                 s2_valid_q, s2_valid_d;
  logic                 s1_load, s2_load, out_xfer;
  logic [OVF_CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

  // A stage loads when empty or when its current content leaves on the same edge.
  assign in_ready = !s1_valid_q || !s2_valid_q || out_ready;
  assign s1_load  = in_valid && in_ready;
  assign s2_load  = s1_valid_q && (!s2_valid_q || out_ready);
  assign out_xfer = s2_valid_q && out_ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    if (s1_load)      s1_valid_d = 1'b1;
    else if (s2_load) s1_valid_d = 1'b0;

    s2_valid_d = s2_valid_q;
    if (s2_load)        s2_valid_d = 1'b1;
    else if (out_ready) s2_valid_d = 1'b0;

    ovf_cnt_d = ovf_cnt_q;
    if (ovf_clr)
      ovf_cnt_d = '0;
    else if (out_xfer && (|out_ovf) && (ovf_cnt_q != '1))
      ovf_cnt_d = ovf_cnt_q + OVF_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      ovf_cnt_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      ovf_cnt_q  <= ovf_cnt_d;
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    addsub_lane #(
      .DATA_SIZE (DATA_SIZE),
      .SIGNED    (SIGNED)
    ) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .s1_load_i (s1_load),
      .s2_load_i (s2_load),
      .op_i      (in_op[gi]),
      .a_i       (in_a[gi*DATA_SIZE +: DATA_SIZE]),
      .b_i       (in_b[gi*DATA_SIZE +: DATA_SIZE]),
      .result_o  (out_result[gi*DATA_SIZE +: DATA_SIZE]),
      .ovf_o     (out_ovf[gi])
    );
  end

  assign out_valid = s2_valid_q;
  assign ovf_count = ovf_cnt_q;

endmodule

// File: tb/tb_addsub_pipe.sv
// Directed bench for addsub_pipe: a signed and an unsigned instance share one stimulus stream.
// Expected values follow ADDSUB_SAT_EN when it is defined for the build.
module tb_addsub_pipe;

  localparam int DS = 8;
  localparam int LN = 4;
  localparam int W  = DS * LN;

`ifdef ADDSUB_SAT_EN
  localparam logic [31:0] V1_RES_S = 32'h0DFFFB7F;
  localparam logic [31:0] V1_RES_U = 32'h0DFF0096;
  localparam logic [31:0] V2_RES_S = 32'hFF007F80;
  localparam logic [31:0] V2_RES_U = 32'h00FF807F;
`else
  localparam logic [31:0] V1_RES_S = 32'h0DFFFB96;
  localparam logic [31:0] V1_RES_U = 32'h0DFFFB96;
  localparam logic [31:0] V2_RES_S = 32'hFF00807F;
  localparam logic [31:0] V2_RES_U = 32'hFF00807F;
`endif
  localparam logic [3:0]  V1_OP = 4'b0101;
  localparam logic [31:0] V1_A  = 32'h10C80564;
  localparam logic [31:0] V1_B  = 32'h03370A32;
  localparam logic [3:0]  V2_OP = 4'b0110;
  localparam logic [31:0] V2_A  = 32'h00FF7F80;
  localparam logic [31:0] V2_B  = 32'h01010101;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          ovf_clr = 1'b0;
  logic [LN-1:0] in_op = '0;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;

  logic          in_ready_s, out_valid_s, in_ready_u, out_valid_u;
  logic [W-1:0]  out_result_s, out_result_u;
  logic [LN-1:0] out_ovf_s, out_ovf_u;
  logic [15:0]   ovf_count_s, ovf_count_u;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  addsub_pipe #(.DATA_SIZE(DS), .LANES(LN), .SIGNED(1)) u_sgn (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .out_valid(out_valid_s),
    .out_ready(out_ready), .out_result(out_result_s), .out_ovf(out_ovf_s),
    .ovf_clr(ovf_clr), .ovf_count(ovf_count_s)
  );

  addsub_pipe #(.DATA_SIZE(DS), .LANES(LN), .SIGNED(0)) u_uns (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_u),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .out_valid(out_valid_u),
    .out_ready(out_ready), .out_result(out_result_u), .out_ovf(out_ovf_u),
    .ovf_clr(ovf_clr), .ovf_count(ovf_count_u)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Sends one beat with out_ready high and checks 2-cycle latency, data and counters.
  task automatic run_vec(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_s, input logic [31:0] exp_u,
                         input logic [3:0] ovf_s, input logic [3:0] ovf_u, input logic [15:0] cnt);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_op     = op;
    in_a      = a;
    in_b      = b;
    tick();
    in_valid = 1'b0;
    #1;
    chk({tag, "_lat1_valid"}, 32'(out_valid_s), 32'd0);
    tick();
    #1;
    chk({tag, "_lat2_valid_s"}, 32'(out_valid_s), 32'd1);
    chk({tag, "_lat2_valid_u"}, 32'(out_valid_u), 32'd1);
    chk({tag, "_res_s"}, out_result_s, exp_s);
    chk({tag, "_res_u"}, out_result_u, exp_u);
    chk({tag, "_ovf_s"}, 32'(out_ovf_s), 32'(ovf_s));
    chk({tag, "_ovf_u"}, 32'(out_ovf_u), 32'(ovf_u));
    tick();
    #1;
    chk({tag, "_cnt_s"}, 32'(ovf_count_s), 32'(cnt));
    chk({tag, "_cnt_u"}, 32'(ovf_count_u), 32'(cnt));
    chk({tag, "_drained"}, 32'(out_valid_s), 32'd0);
  endtask

  // Streams n overflowing beats back to back, then lets the pipe drain.
  task automatic feed_ovf(input int n);
    out_ready = 1'b1;
    in_op     = V1_OP;
    in_a      = V1_A;
    in_b      = V1_B;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    int         tx;
    int         rx;
    logic       acc;
    logic       xfer;
    logic [7:0] bt;

    @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid_s), 32'd0);
    chk("rst_in_ready", 32'(in_ready_s), 32'd1);
    chk("rst_result", out_result_s, 32'd0);
    chk("rst_ovf", 32'(out_ovf_s), 32'd0);
    chk("rst_count", 32'(ovf_count_s), 32'd0);
    chk("rst_out_valid_u", 32'(out_valid_u), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_vec("v1", V1_OP, V1_A, V1_B, V1_RES_S, V1_RES_U, 4'b0001, 4'b0010, 16'd1);
    run_vec("v2", V2_OP, V2_A, V2_B, V2_RES_S, V2_RES_U, 4'b0011, 4'b1100, 16'd2);

    // Backpressure: out_ready low for six cycles while five beats are offered.
    tx = 0;
    rx = 0;
    for (int c = 0; c < 30 && rx < 5; c++) begin
      out_ready = (c >= 6);
      in_valid  = (tx < 5);
      bt        = 8'(tx + 1);
      in_op     = 4'hF;
      in_a      = {4{bt}};
      in_b      = 32'h10101010;
      #1;
      if (c == 6) chk("bp_accepted_before_release", 32'(tx), 32'd2);
      if (c >= 2 && c <= 5) begin
        chk("bp_in_ready_low", 32'(in_ready_s), 32'd0);
        chk("bp_held_valid", 32'(out_valid_s), 32'd1);
        chk("bp_held_result", out_result_s, 32'h11111111);
      end
      acc  = in_valid && in_ready_s;
      xfer = out_valid_s && out_ready;
      if (xfer) begin
        bt = 8'(rx + 17);
        chk("bp_order_s", out_result_s, {4{bt}});
        chk("bp_order_u", out_result_u, {4{bt}});
        rx++;
      end
      @(posedge clk);
      if (acc) tx++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("bp_beats_out", 32'(rx), 32'd5);

    // Reset with two beats in flight.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_op     = V1_OP;
    in_a      = V1_A;
    in_b      = V1_B;
    tick();
    in_op = V2_OP;
    in_a  = V2_A;
    in_b  = V2_B;
    tick();
    in_valid = 1'b0;
    #1;
    chk("mid_inflight_valid", 32'(out_valid_s), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid_s), 32'd0);
    chk("mid_rst_result", out_result_s, 32'd0);
    chk("mid_rst_ovf", 32'(out_ovf_u), 32'd0);
    chk("mid_rst_count", 32'(ovf_count_s), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready_s), 32'd1);
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      chk("mid_beats_lost", 32'(out_valid_s), 32'd0);
    end
    run_vec("post_rst", 4'hF, 32'h07070707, 32'h10101010, 32'h17171717, 32'h17171717,
            4'b0000, 4'b0000, 16'd0);

    // Counter saturation after 0x10001 overflowing transfers.
    feed_ovf(65534);
    #1;
    chk("cnt_fffe_s", 32'(ovf_count_s), 32'h0000FFFE);
    chk("cnt_fffe_u", 32'(ovf_count_u), 32'h0000FFFE);
    feed_ovf(3);
    #1;
    chk("cnt_sat_s", 32'(ovf_count_s), 32'h0000FFFF);
    chk("cnt_sat_u", 32'(ovf_count_u), 32'h0000FFFF);

    // Clear coincident with an overflowing transfer: clear wins.
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    ovf_clr = 1'b1;
    #1;
    chk("clr_xfer_valid", 32'(out_valid_s), 32'd1);
    chk("clr_xfer_ovf", 32'(out_ovf_s), 32'd1);
    tick();
    ovf_clr = 1'b0;
    #1;
    chk("clr_count_s", 32'(ovf_count_s), 32'd0);
    chk("clr_count_u", 32'(ovf_count_u), 32'd0);
    run_vec("after_clr", V1_OP, V1_A, V1_B, V1_RES_S, V1_RES_U, 4'b0001, 4'b0010, 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
